// File: rtl/am_demod_meas.sv
// am_demod_meas: envelope-detecting AM demodulator. It also measures the
// modulation depth (%) and the modulation frequency (crossings per gate) over
// back-to-back gate windows.
module am_demod_meas #(
  parameter int DW          = 10,
  parameter int LPF_SHIFT   = 4,
  parameter int GATE_CYCLES = 8192,  // must exceed 8 so a window never ends inside CALC
  parameter int HYST        = 8,
  parameter int FREQ_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DW-1:0]     ad_data,
  output logic [DW-1:0]     demod_out,
  output logic [7:0]        ma,
  output logic [FREQ_W-1:0] freq,
  output logic              meas_valid
);
  localparam int EW  = DW - 1;            // envelope integer width
  localparam int EW1 = EW + 1;
  localparam int AW  = EW + LPF_SHIFT;    // envelope accumulator width
  localparam int NW  = EW + 7;            // divider width: 100*span < 128*2^EW
  localparam int GW  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]  GLAST  = GW'(GATE_CYCLES - 1);
  localparam logic [EW-1:0]  EMAX   = '1;
  localparam logic [EW:0]    HYST_V = EW1'(HYST);
  localparam logic [NW-1:0]  C100   = NW'(100);

  typedef enum logic [1:0] {IDLE, PRIME, ACQ, CALC} state_t;
  state_t r_state, w_state_n;

  // datapath
  logic signed [DW-1:0] r_x, w_x, w_neg, w_dd;
  logic [EW-1:0]        r_r, w_abs, w_e, r_mid;
  logic [AW-1:0]        r_env, w_env_n;
  logic signed [AW+1:0] w_diff, w_step, w_sum;
  logic [DW-1:0]        w_dem_n;
  // window statistics
  logic [GW-1:0]        r_gcnt;
  logic [EW-1:0]        r_emax, r_emin, w_max_n, w_min_n, w_mid_n, w_span;
  logic [EW:0]          w_msum, w_lo, w_hi, w_hsum;
  logic [FREQ_W-1:0]    r_cnt, w_cnt_n, r_cntl;
  logic                 r_arm, w_arm_n;
  // divider
  logic [NW-1:0]        r_rem, r_dsh, w_span100;
  logic [6:0]           r_q;
  logic [2:0]           r_ccnt;
  logic                 r_dz;
  logic                 w_tick, w_last, w_latch, w_done;

  // Rectifier, one-pole envelope IIR and DC removal against last window's midpoint
  always_comb begin
    w_x   = {~ad_data[DW-1], ad_data[DW-2:0]};  // offset-binary minus midscale
    w_neg = -r_x;
    if (!r_x[DW-1])              w_abs = r_x[EW-1:0];
    else if (r_x[EW-1:0] == '0)  w_abs = EMAX;  // most negative code has no positive twin
    else                         w_abs = w_neg[EW-1:0];
    w_e    = r_env[AW-1:LPF_SHIFT];
    w_diff = $signed({2'b00, r_r, {LPF_SHIFT{1'b0}}}) - $signed({2'b00, r_env});
    w_step = w_diff >>> LPF_SHIFT;
    w_sum  = $signed({2'b00, r_env}) + w_step;
    if (w_sum[AW+1])    w_env_n = '0;
    else if (w_sum[AW]) w_env_n = '1;
    else                w_env_n = w_sum[AW-1:0];
    // e and mid are both EW-bit unsigned, so the DW-bit signed difference cannot overflow
    w_dd    = $signed({1'b0, w_e}) - $signed({1'b0, r_mid});
    w_dem_n = {~w_dd[DW-1], w_dd[DW-2:0]};
  end

  // Datapath registers; disabled means flushed to zero envelope and midscale output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !en) begin
      r_x <= '0; r_r <= '0; r_env <= '0;
      demod_out <= {1'b1, {(DW-1){1'b0}}};
    end else begin
      r_x <= w_x; r_r <= w_abs; r_env <= w_env_n; demod_out <= w_dem_n;
    end
  end

  // Window extremes, hysteretic rising-crossing detection, FSM next state
  always_comb begin
    w_max_n = (w_e > r_emax) ? w_e : r_emax;
    w_min_n = (w_e < r_emin) ? w_e : r_emin;
    w_msum  = {1'b0, w_max_n} + {1'b0, w_min_n};
    w_mid_n = w_msum[EW:1];
    w_span  = (w_max_n >= w_min_n) ? (w_max_n - w_min_n) : '0;
    w_span100 = NW'(w_span) * C100;
    w_lo    = ({1'b0, r_mid} > HYST_V) ? ({1'b0, r_mid} - HYST_V) : '0;
    w_hsum  = {1'b0, r_mid} + HYST_V;
    w_hi    = (w_hsum > {1'b0, EMAX}) ? {1'b0, EMAX} : w_hsum;
    w_arm_n = r_arm;
    w_cnt_n = r_cnt;
    if ({1'b0, w_e} < w_lo) w_arm_n = 1'b1;
    else if (r_arm && ({1'b0, w_e} > w_hi)) begin
      w_arm_n = 1'b0;
      if (r_cnt != '1) w_cnt_n = r_cnt + 1'b1;
    end
    w_tick  = en && (r_state != IDLE);
    w_last  = w_tick && (r_gcnt == GLAST);
    w_latch = w_last && (r_state == ACQ);
    w_done  = en && (r_state == CALC) && (r_ccnt == 3'd7);
    w_state_n = r_state;
    if (!en) w_state_n = IDLE;
    else begin
      case (r_state)
        IDLE:    w_state_n = PRIME;
        PRIME:   if (w_last) w_state_n = ACQ;
        ACQ:     if (w_last) w_state_n = CALC;
        CALC:    if (r_ccnt == 3'd7) w_state_n = ACQ;
        default: w_state_n = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  // Gate counter and window statistics; windows run back to back while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gcnt <= '0; r_emax <= '0; r_emin <= '0; r_cnt <= '0; r_arm <= 1'b0; r_mid <= '0;
    end else if (!w_tick) begin
      r_gcnt <= '0; r_emax <= '0; r_emin <= '1; r_cnt <= '0; r_arm <= 1'b0; r_mid <= '0;
    end else begin
      r_arm <= w_arm_n;
      if (w_last) begin
        r_gcnt <= '0; r_emax <= '0; r_emin <= '1; r_cnt <= '0; r_mid <= w_mid_n;
      end else begin
        r_gcnt <= r_gcnt + 1'b1; r_emax <= w_max_n; r_emin <= w_min_n; r_cnt <= w_cnt_n;
      end
    end
  end

  // Restoring divide 100*(max-min)/(max+min), one quotient bit per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0; r_dsh <= '0; r_q <= '0; r_ccnt <= '0; r_dz <= 1'b0; r_cntl <= '0;
    end else if (w_latch) begin
      r_rem  <= w_span100;
      r_dsh  <= {w_msum, 6'b0};
      r_q    <= '0;
      r_ccnt <= '0;
      r_dz   <= (w_msum == '0);
      r_cntl <= w_cnt_n;
    end else if (en && (r_state == CALC) && (r_ccnt != 3'd7)) begin
      if (r_rem >= r_dsh) begin
        r_rem <= r_rem - r_dsh;
        r_q   <= {r_q[5:0], 1'b1};
      end else begin
        r_q   <= {r_q[5:0], 1'b0};
      end
      r_dsh  <= r_dsh >> 1;
      r_ccnt <= r_ccnt + 3'd1;
    end
  end

  // Measurement outputs; hold between updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0; freq <= '0; meas_valid <= 1'b0;
    end else begin
      meas_valid <= w_done;
      if (w_done) begin
        ma   <= r_dz ? 8'd0 : ((r_q > 7'd100) ? 8'd100 : {1'b0, r_q});
        freq <= r_cntl;
      end
    end
  end
endmodule

// File: tb/tb_am_demod_meas.sv
// tb_am_demod_meas: randomized stimulus with a per-cycle expectation queue
// filled by a behavioural model and drained by an independent monitor.
module tb_am_demod_meas;
  localparam int DW = 10, L = 4, G = 256, HY = 8, FW = 8, MID = 512, EMX = 511;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [DW-1:0] ad_data = '0;
  logic [DW-1:0] demod_out;
  logic [7:0]    ma;
  logic [FW-1:0] freq;
  logic          meas_valid;

  am_demod_meas #(.DW(DW), .LPF_SHIFT(L), .GATE_CYCLES(G), .HYST(HY), .FREQ_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ad_data(ad_data),
    .demod_out(demod_out), .ma(ma), .freq(freq), .meas_valid(meas_valid));

  always #5 clk = ~clk;

  typedef struct { int dem; int ma; int fr; bit vld; } exp_t;
  typedef struct { int stamp; int ma; int fr; } meas_t;
  exp_t  expq[$];
  meas_t pend[$];

  int n_tests = 0, n_fail = 0, mon_k = 0;

  // behavioural model state
  int mx = 0, mr = 0, menv = 0, mdem = MID, mmid = 0, mph = 0, mg = 0;
  int emax = 0, emin = EMX, mcnt = 0, mma = 0, mfr = 0, mk = 0;
  bit marm = 0;
  int ph = 0;

  task automatic model_step(input bit rst, input bit e_n, input int ad);
    bit vld; int ev, d, st, lo, hi, ax; meas_t m; exp_t ex;
    vld = 1'b0;
    if (!rst || !e_n) begin
      mx = 0; mr = 0; menv = 0; mdem = MID; mph = 0; mg = 0;
      emax = 0; emin = EMX; mcnt = 0; marm = 0; mmid = 0;
      pend.delete();
      if (!rst) begin mma = 0; mfr = 0; end
    end else begin
      ev = menv / (1 << L);
      if (pend.size() > 0 && pend[0].stamp == mk) begin
        mma = pend[0].ma; mfr = pend[0].fr; vld = 1'b1;
        void'(pend.pop_front());
      end
      mdem = ev - mmid + MID;
      if (mdem < 0) mdem = 0;
      if (mdem > 1023) mdem = 1023;
      d  = mr * (1 << L) - menv;
      st = (d >= 0) ? d / (1 << L) : -((-d + (1 << L) - 1) / (1 << L));
      menv = menv + st;
      if (menv < 0) menv = 0;
      if (menv > (1 << (EMX == 511 ? 13 : 13)) - 1) menv = (1 << 13) - 1;
      ax = (mx < 0) ? -mx : mx;
      mr = (ax > EMX) ? EMX : ax;
      mx = ad - MID;
      if (mph == 0) begin
        mph = 1; mg = 0; emax = 0; emin = EMX; mcnt = 0; marm = 0;
      end else begin
        if (ev > emax) emax = ev;
        if (ev < emin) emin = ev;
        lo = (mmid > HY) ? mmid - HY : 0;
        hi = (mmid + HY > EMX) ? EMX : mmid + HY;
        if (ev < lo) marm = 1;
        else if (marm && ev > hi) begin
          marm = 0;
          if (mcnt < (1 << FW) - 1) mcnt++;
        end
        if (mg == G - 1) begin
          if (mph == 2) begin
            m.stamp = mk + 8;
            m.ma = (emax + emin == 0) ? 0 : (100 * (emax - emin)) / (emax + emin);
            if (m.ma > 100) m.ma = 100;
            m.fr = mcnt;
            pend.push_back(m);
          end
          mmid = (emax + emin) / 2;
          mph = 2; mg = 0; emax = 0; emin = EMX; mcnt = 0;
        end else mg++;
      end
    end
    ex.dem = mdem; ex.ma = mma; ex.fr = mfr; ex.vld = vld;
    expq.push_back(ex);
    mk++;
  endtask

  // drive one cycle's inputs away from the active edge and predict its result
  task automatic cyc(input bit r, input bit e_n, input int ad);
    rst_n = r; en = e_n; ad_data = ad[DW-1:0];
    model_step(r, e_n, ad);
    @(negedge clk);
  endtask

  // AM test tone: carrier at fs/2, 128-cycle modulation period, small noise
  task automatic am_cycle(input bit e_n, input real m);
    real a; int v;
    a = 250.0 * (1.0 + m * $sin(6.283185307 * real'(ph) / 128.0));
    v = $rtoi(a) + int'($urandom_range(0, 6)) - 3;
    if (v < 0) v = 0;
    if (ph % 2 != 0) v = -v;
    v = v + MID;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    ph++;
    cyc(1'b1, e_n, v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, mon_k, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_tests++; n_fail++;
    $display("FAIL %s bound expired at cyc=%0d got=timeout exp=event", nm, mk);
  endtask

  // monitor: compare every post-edge output against the queued expectation
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      exp_t ex;
      ex = expq.pop_front();
      chk("demod_out", int'(demod_out), ex.dem);
      chk("ma", int'(ma), ex.ma);
      chk("freq", int'(freq), ex.fr);
      chk("meas_valid", int'(meas_valid), int'(ex.vld));
      mon_k++;
    end
  end

  initial begin
    int guard;
    // reset
    repeat (3) cyc(1'b0, 1'b0, 0);
    // DC midscale for prime + two gates and margin
    repeat (3 * G + 20) cyc(1'b1, 1'b1, MID);
    // moderate then full modulation
    repeat (5 * G) am_cycle(1'b1, 0.5);
    repeat (5 * G) am_cycle(1'b1, 1.0);
    // enable dropped mid-window for 100 cycles
    guard = 0;
    while (!(mph == 2 && mg == G / 2) && guard < 4 * G) begin am_cycle(1'b1, 0.5); guard++; end
    if (guard >= 4 * G) bound_fail("align_mid");
    repeat (100) am_cycle(1'b0, 0.5);
    repeat (4 * G) am_cycle(1'b1, 0.5);
    // enable dropped exactly on a window's last cycle
    guard = 0;
    while (!(mph == 2 && mg == G - 1) && guard < 4 * G) begin am_cycle(1'b1, 1.0); guard++; end
    if (guard >= 4 * G) bound_fail("align_end");
    am_cycle(1'b0, 1.0);
    repeat (3 * G + 20) am_cycle(1'b1, 1.0);
    // reset pulse while the divider is busy
    guard = 0;
    while (pend.size() == 0 && guard < 4 * G) begin am_cycle(1'b1, 0.5); guard++; end
    if (guard >= 4 * G) bound_fail("align_calc");
    repeat (3) am_cycle(1'b1, 0.5);
    repeat (2) cyc(1'b0, 1'b1, MID);
    repeat (3 * G + 20) am_cycle(1'b1, 0.5);
    // full-scale alternation saturates the rectifier
    for (int i = 0; i < 6 * G; i++) cyc(1'b1, 1'b1, (i % 2 != 0) ? 1023 : 0);
    // random samples with occasional enable drops
    for (int i = 0; i < 4 * G; i++)
      cyc(1'b1, ($urandom_range(0, 299) != 0), int'($urandom_range(0, 1023)));
    repeat (3) @(negedge clk);
    guard = 0;
    while (expq.size() > 0 && guard < 10) begin @(negedge clk); guard++; end
    if (expq.size() > 0) bound_fail("drain");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
